lzd_norm: RTL and testbench
===========================

Name: lzd_norm

Overview:
- Two-stage pipelined normalizer; the consumer-side counterpart of the 48-bit leading-zero detector.
- Accepts a 48-bit operand, its leading-zero count (numz) and an exponent.
- Left-shifts the operand so bit 47 is set and reduces the exponent by numz, with saturation.
- Sits between the LZD and the float packer in the Box-Muller datapath; valid/ready on both sides.

Parameters:
- DW, 48, operand and result width
- SW, 6, shift-count width
- EW, 8, exponent width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low system reset
- scan_in0  input  1  test scan data in
- scan_en  input  1  test scan enable
- test_mode  input  1  test mode select
- scan_out0  output  1  test scan data out
- in_valid  input  1  din/numz/exp_in valid
- in_ready  output  1  block accepts this cycle
- din  input  DW  operand to normalize
- numz  input  SW  leading-zero count of din (0..48)
- exp_in  input  EW  unsigned exponent of din
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- dout  output  DW  normalized operand
- exp_out  output  EW  adjusted exponent
- zero  output  1  operand was all-zero
- uflow  output  1  exponent saturated to 0
- norm_err  output  1  sticky normalization error (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valids cleared
  - out_valid=0; dout=0; exp_out=0; zero=0; uflow=0; norm_err=0; scan_out0=0
- Transfer occurs when valid and ready are both 1 on a rising clk edge.
- Stage 1 (capture on input transfer):
  - Clamp: nz = (numz>48) ? 48 : numz.
  - s1_data = din << (nz[5:4]*16); a shift of 48 yields 0.
  - s1_nz = nz; s1_exp = exp_in.
- Stage 2 (capture on stage1->stage2 advance):
  - dout = s1_data << s1_nz[3:0].
  - exp_out = (exp_in >= nz) ? exp_in - nz : 0; uflow = (exp_in < nz).
  - zero = (nz==48). When zero=1, force dout=0, exp_out=0, uflow=0.
- Latency: 2 cycles from input transfer to out_valid with out_ready held 1. Throughput: 1 per cycle.
- Flow control:
  - stage2 loads when ~s2_valid | out_ready
  - stage1 advances under the same condition
  - in_ready = ~s1_valid | (~s2_valid | out_ready)
  - in_ready has no combinational path from in_valid.
- Stall: out_valid=1 with out_ready=0 holds dout/exp_out/zero/uflow stable; stage1 holds; in_ready drops once stage1 is full.
- Simultaneous transfer into stage1 and stage1->stage2 in the same cycle: both occur, no bubble.
- Output registers update only on stage2 load; values persist after out_valid falls.
- Reset mid-operation: in-flight data discarded; first post-reset output appears 2 cycles after the first post-reset input transfer.
- Scan ports are pass-through for DFT insertion: scan_out0 = 0 in RTL.

Optional Feature:
- Macro: LZD_NORM_CHECK_EN.
- Defined: on every stage2 load with zero=0, if the new dout[47]==0 (numz inconsistent with din), norm_err is set on the following edge. It stays set until reset.
- Not defined: norm_err tied to 0; no check logic is compiled in.

Test Plan:
- din=48'h000001234567, numz=23, exp_in=100, out_ready=1 -> 2 cycles later out_valid=1, dout=48'h91A2B3800000, exp_out=77, zero=0, uflow=0.
- din=0, numz=48, exp_in=5 -> dout=0, exp_out=0, zero=1, uflow=0; numz=60 gives the same result.
- din=48'h000000000001, numz=47, exp_in=10 -> dout=48'h800000000000, exp_out=0, uflow=1.
- Burst of 8 back-to-back inputs with out_ready=1 -> 8 consecutive out_valid cycles, in order, in_ready never drops. Then out_ready=0 for 3 cycles -> dout held, in_ready=0 after stage1 fills, no loss or duplication on release.
- Assert reset=0 asynchronously mid-burst -> out_valid, in-flight flags and outputs clear immediately without a clock edge; next input emerges 2 cycles after acceptance.
- With LZD_NORM_CHECK_EN: din=48'h400000000000, numz=0 -> dout[47]=0, norm_err=1 and sticky. Without the macro -> norm_err stays 0.

Source files
------------

// File: rtl/lzd_norm_if.sv
// Handshake and data bundle for lzd_norm: upstream operand/numz/exponent side and downstream result side.
// The slave modport is the normalizer's view; master is the producer/consumer view.
interface lzd_norm_if #(
   parameter int DW = 48,
   parameter int SW = 6,
   parameter int EW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] din;
   logic [SW-1:0] numz;
   logic [EW-1:0] exp_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dout;
   logic [EW-1:0] exp_out;
   logic          zero;
   logic          uflow;
   logic          norm_err;

   modport master (
      output in_valid, din, numz, exp_in, out_ready,
      input  in_ready, out_valid, dout, exp_out, zero, uflow, norm_err
   );

   modport slave (
      input  in_valid, din, numz, exp_in, out_ready,
      output in_ready, out_valid, dout, exp_out, zero, uflow, norm_err
   );
endinterface

// File: rtl/lzd_norm.sv
// Two-stage normalizer: coarse 16-bit-granular shift in stage 1, fine shift plus exponent adjust in stage 2.
// Optional sticky consistency check on the normalized MSB is enabled by defining LZD_NORM_CHECK_EN.
module lzd_norm #(
   parameter int DW = 48,
   parameter int SW = 6,
   parameter int EW = 8
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   scan_in0,
   input  logic   scan_en,
   input  logic   test_mode,
   output logic   scan_out0,
   lzd_norm_if.slave bus
);

   logic          s1_valid;
   logic [DW-1:0] s1_data;
   logic [SW-1:0] s1_nz;
   logic [EW-1:0] s1_exp;

   logic          s2_valid;
   logic [DW-1:0] dout_q;
   logic [EW-1:0] exp_q;
   logic          zero_q;
   logic          uflow_q;

   logic          adv;
   logic          s2_load;
   logic          in_fire;
   logic [SW-1:0] nz;
   logic [DW-1:0] coarse;
   logic [DW-1:0] fine;
   logic          s1_zero;
   logic          s1_uflow;
   logic [EW-1:0] exp_diff;
   logic          unused_scan;

   assign adv         = ~s2_valid | bus.out_ready;
   assign s2_load     = adv & s1_valid;
   assign bus.in_ready = ~s1_valid | adv;
   assign in_fire     = bus.in_valid & bus.in_ready;

   // Counts above the operand width are clamped; a count of DW then shifts everything out.
   assign nz     = (bus.numz > SW'(DW)) ? SW'(DW) : bus.numz;
   assign coarse = bus.din << {nz[SW-1:4], 4'b0000};

   assign fine     = s1_data << s1_nz[3:0];
   assign s1_zero  = (s1_nz == SW'(DW));
   assign s1_uflow = (EW'(s1_nz) > s1_exp);
   assign exp_diff = s1_exp - EW'(s1_nz);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_nz    <= '0;
         s1_exp   <= '0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (in_fire) begin
            s1_data <= coarse;
            s1_nz   <= nz;
            s1_exp  <= bus.exp_in;
         end
      end
   end

   // Result registers change only when stage 2 actually loads, so values persist after out_valid drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         dout_q   <= '0;
         exp_q    <= '0;
         zero_q   <= 1'b0;
         uflow_q  <= 1'b0;
      end else begin
         if (adv) s2_valid <= s1_valid;
         if (s2_load) begin
            dout_q  <= s1_zero ? '0 : fine;
            exp_q   <= (s1_zero || s1_uflow) ? '0 : exp_diff;
            zero_q  <= s1_zero;
            uflow_q <= s1_uflow & ~s1_zero;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.dout      = dout_q;
   assign bus.exp_out   = exp_q;
   assign bus.zero      = zero_q;
   assign bus.uflow     = uflow_q;

`ifdef LZD_NORM_CHECK_EN
   logic err_pend;
   logic norm_err_q;

   // A non-zero result whose MSB is clear means numz disagreed with din; flag it one edge later and hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_pend   <= 1'b0;
         norm_err_q <= 1'b0;
      end else begin
         err_pend   <= s2_load & ~s1_zero & ~fine[DW-1];
         norm_err_q <= norm_err_q | err_pend;
      end
   end

   assign bus.norm_err = norm_err_q;
`else
   assign bus.norm_err = 1'b0;
`endif

   assign scan_out0   = 1'b0;
   assign unused_scan = ^{scan_in0, scan_en, test_mode};

endmodule

// File: tb/tb_lzd_norm.sv
// Scoreboard bench for lzd_norm: directed vectors push expected results, a negedge monitor pops and compares.
module tb_lzd_norm;

   typedef struct packed {
      logic [47:0] dout;
      logic [7:0]  exp_out;
      logic        zero;
      logic        uflow;
   } exp_t;

`ifdef LZD_NORM_CHECK_EN
   localparam bit EXP_ERR = 1'b1;
`else
   localparam bit EXP_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic scan_in0 = 1'b0;
   logic scan_en = 1'b0;
   logic test_mode = 1'b0;
   logic scan_out0;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];

   lzd_norm_if #(.DW(48), .SW(6), .EW(8)) bus ();

   lzd_norm #(.DW(48), .SW(6), .EW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .scan_in0  (scan_in0),
      .scan_en   (scan_en),
      .test_mode (test_mode),
      .scan_out0 (scan_out0),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Present one operand and hold it until accepted; the expected result is queued at the accepting edge.
   task automatic applyStimulus(input logic [47:0] d, input logic [5:0] nz, input logic [7:0] e,
                                input logic [47:0] ed, input logic [7:0] ee, input logic ez,
                                input logic eu, input bit must_be_ready);
      bit accepted = 1'b0;
      exp_t item;
      item = '{dout: ed, exp_out: ee, zero: ez, uflow: eu};
      bus.din      = d;
      bus.numz     = nz;
      bus.exp_in   = e;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (must_be_ready && i == 0) checkOutput("burst_in_ready", 64'(bus.in_ready), 64'd1);
         if (bus.in_ready) begin
            accepted = 1'b1;
            sb.push_back(item);
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!accepted) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout in_ready=%0b required=1", bus.in_ready);
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_output dout=%h required=none", bus.dout);
            end else begin
               e = sb.pop_front();
               checkOutput("dout", 64'(bus.dout), 64'(e.dout));
               checkOutput("exp_out", 64'(bus.exp_out), 64'(e.exp_out));
               checkOutput("zero", 64'(bus.zero), 64'(e.zero));
               checkOutput("uflow", 64'(bus.uflow), 64'(e.uflow));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.numz      = '0;
      bus.exp_in    = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_dout", 64'(bus.dout), 64'd0);
      checkOutput("rst_exp_out", 64'(bus.exp_out), 64'd0);
      checkOutput("rst_flags", 64'({bus.zero, bus.uflow, bus.norm_err}), 64'd0);
      checkOutput("rst_scan_out0", 64'(scan_out0), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed vectors");
      applyStimulus(48'h000001234567, 6'd23, 8'd100, 48'h91A2B3800000, 8'd77, 1'b0, 1'b0, 1'b0);
      checkOutput("latency_edge1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("latency_edge2_valid", 64'(bus.out_valid), 64'd1);
      applyStimulus(48'h0, 6'd48, 8'd5, 48'h0, 8'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(48'h0, 6'd60, 8'd5, 48'h0, 8'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(48'h000000000001, 6'd47, 8'd10, 48'h800000000000, 8'd0, 1'b0, 1'b1, 1'b0);
      waitDrain();
      checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("persist_dout", 64'(bus.dout), 64'h800000000000);

      $display("[TB] back-to-back burst");
      applyStimulus(48'h800000000000, 6'd0,  8'd50,  48'h800000000000, 8'd50,  1'b0, 1'b0, 1'b1);
      applyStimulus(48'h000000000080, 6'd40, 8'd200, 48'h800000000000, 8'd160, 1'b0, 1'b0, 1'b1);
      applyStimulus(48'h00FFFF000000, 6'd8,  8'd8,   48'hFFFF00000000, 8'd0,   1'b0, 1'b0, 1'b1);
      applyStimulus(48'h0000ABCD0000, 6'd16, 8'd255, 48'hABCD00000000, 8'd239, 1'b0, 1'b0, 1'b1);
      applyStimulus(48'h000000000003, 6'd46, 8'd3,   48'hC00000000000, 8'd0,   1'b0, 1'b1, 1'b1);
      applyStimulus(48'h123456789ABC, 6'd3,  8'd3,   48'h91A2B3C4D5E0, 8'd0,   1'b0, 1'b0, 1'b1);
      applyStimulus(48'h000000000000, 6'd63, 8'd77,  48'h000000000000, 8'd0,   1'b1, 1'b0, 1'b1);
      applyStimulus(48'h000000010000, 6'd31, 8'd31,  48'h800000000000, 8'd0,   1'b0, 1'b0, 1'b1);
      waitDrain();

      $display("[TB] downstream stall");
      bus.out_ready = 1'b0;
      fork
         begin
            applyStimulus(48'h000001234567, 6'd23, 8'd100, 48'h91A2B3800000, 8'd77, 1'b0, 1'b0, 1'b0);
            applyStimulus(48'h0000ABCD0000, 6'd16, 8'd255, 48'hABCD00000000, 8'd239, 1'b0, 1'b0, 1'b0);
            applyStimulus(48'h123456789ABC, 6'd3,  8'd3,   48'h91A2B3C4D5E0, 8'd0,   1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
               checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
               checkOutput("stall_dout", 64'(bus.dout), 64'h91A2B3800000);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      waitDrain();
      checkOutput("norm_err_clean", 64'(bus.norm_err), 64'd0);

      $display("[TB] inconsistent numz");
      applyStimulus(48'h400000000000, 6'd0, 8'd20, 48'h400000000000, 8'd20, 1'b0, 1'b0, 1'b0);
      waitDrain();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("norm_err_set", 64'(bus.norm_err), 64'(EXP_ERR));
      applyStimulus(48'h000001234567, 6'd23, 8'd100, 48'h91A2B3800000, 8'd77, 1'b0, 1'b0, 1'b0);
      waitDrain();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("norm_err_sticky", 64'(bus.norm_err), 64'(EXP_ERR));

      $display("[TB] reset mid-burst");
      applyStimulus(48'h000000000080, 6'd40, 8'd200, 48'h800000000000, 8'd160, 1'b0, 1'b0, 1'b0);
      applyStimulus(48'h000000000003, 6'd46, 8'd3,   48'hC00000000000, 8'd0,   1'b0, 1'b1, 1'b0);
      applyStimulus(48'h0000ABCD0000, 6'd16, 8'd255, 48'hABCD00000000, 8'd239, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_reset_uflow", 64'(bus.uflow), 64'd1);
      checkOutput("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("async_rst_dout", 64'(bus.dout), 64'd0);
      checkOutput("async_rst_exp_out", 64'(bus.exp_out), 64'd0);
      checkOutput("async_rst_flags", 64'({bus.zero, bus.uflow, bus.norm_err}), 64'd0);
      checkOutput("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      sb.delete();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(48'h000000000001, 6'd47, 8'd10, 48'h800000000000, 8'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("post_rst_edge1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("post_rst_edge2_valid", 64'(bus.out_valid), 64'd1);
      waitDrain();
      checkOutput("post_rst_scan_out0", 64'(scan_out0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
